// File: rtl/yonga_lz4_wb_multi_bridge_if.sv
// Wishbone-slave bus bundle for the multi-channel LZ4 bridge.
// The master drives the request; the slave returns a one-cycle ack with read data.
interface yonga_lz4_wb_multi_bridge_if #(
  parameter int unsigned AW = 8
);
  logic          wb_valid;
  logic          wb_we;
  logic [3:0]    wb_sel;
  logic [AW-1:0] wb_adr;
  logic [31:0]   wb_wdata;
  logic [31:0]   wb_rdata;
  logic          wb_ack;

  modport master (
    output wb_valid, wb_we, wb_sel, wb_adr, wb_wdata,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_valid, wb_we, wb_sel, wb_adr, wb_wdata,
    output wb_rdata, wb_ack
  );
endinterface

// File: rtl/yonga_lz4_wb_multi_bridge.sv
// Wishbone front-end for NUM_CH LZ4 decoder channels: per-channel in/out byte FIFOs, status, irq.
// Define BRIDGE_STICKY_ERR_EN to add sticky overflow/underflow flags that also feed irq.
module yonga_lz4_wb_multi_bridge #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AW         = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  yonga_lz4_wb_multi_bridge_if.slave wb,
  output logic [NUM_CH-1:0]          cmp_valid,
  input  logic [NUM_CH-1:0]          cmp_ready,
  output logic [8*NUM_CH-1:0]        cmp_data,
  input  logic [NUM_CH-1:0]          dec_valid,
  output logic [NUM_CH-1:0]          dec_ready,
  input  logic [8*NUM_CH-1:0]        dec_data,
  output logic [NUM_CH-1:0]          irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);

  typedef enum logic {StIdle, StAck} state_e;

  state_e        r_state, w_state_nxt;
  logic          w_acc;
  logic          r_ack;
  logic [31:0]   r_rdata, w_rdata_nxt;

  logic [AW-1:0] w_adr;
  logic [3:0]    w_ch;
  logic [1:0]    w_reg;
  logic          w_sel0;

  logic [7:0]    r_in_mem  [NUM_CH][FIFO_DEPTH];
  logic [7:0]    r_out_mem [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0] r_in_wp   [NUM_CH];
  logic [PW-1:0] r_in_rp   [NUM_CH];
  logic [PW-1:0] r_out_wp  [NUM_CH];
  logic [PW-1:0] r_out_rp  [NUM_CH];
  logic [CW-1:0] r_in_cnt  [NUM_CH];
  logic [CW-1:0] r_out_cnt [NUM_CH];

  logic [NUM_CH-1:0] r_irq_en, r_irq;
  logic [NUM_CH-1:0] w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic [NUM_CH-1:0] w_hit, w_in_wr, w_out_rd, w_ctrl_wr, w_flush;
  logic [NUM_CH-1:0] w_in_push, w_in_pop, w_out_push, w_out_pop;
  logic [NUM_CH-1:0] w_ovf, w_udf;
  logic              w_unused_bits;

  assign w_adr  = wb.wb_adr;
  assign w_ch   = w_adr[7:4];
  assign w_reg  = w_adr[3:2];
  assign w_sel0 = wb.wb_sel[0];

  // Address low bits, upper data bytes and upper lanes carry no meaning here.
  assign w_unused_bits = ^{w_adr, wb.wb_wdata, wb.wb_sel};

  // Bus FSM: one access per IDLE cycle, ack during the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_acc;
      if (w_acc) begin
        r_rdata <= w_rdata_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (wb.wb_valid) begin
          w_acc       = 1'b1;
          w_state_nxt = StAck;
        end
      end
      StAck:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign wb.wb_ack   = r_ack;
  assign wb.wb_rdata = r_rdata;

  // Per-channel FIFO flags and access strobes.
  always_comb begin
    w_in_full  = '0;
    w_in_empty = '0;
    w_out_full = '0;
    w_out_empty = '0;
    w_hit      = '0;
    w_in_wr    = '0;
    w_out_rd   = '0;
    w_ctrl_wr  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_in_full[c]   = (r_in_cnt[c] == FullCnt);
      w_in_empty[c]  = (r_in_cnt[c] == '0);
      w_out_full[c]  = (r_out_cnt[c] == FullCnt);
      w_out_empty[c] = (r_out_cnt[c] == '0);
      w_hit[c]       = w_acc && (w_ch == 4'(c));
      w_in_wr[c]     = w_hit[c] && wb.wb_we && (w_reg == 2'd0) && w_sel0;
      w_out_rd[c]    = w_hit[c] && !wb.wb_we && (w_reg == 2'd1);
      w_ctrl_wr[c]   = w_hit[c] && wb.wb_we && (w_reg == 2'd3) && w_sel0;
    end
  end

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign w_in_push  = w_in_wr & ~w_in_full;
  assign w_in_pop   = ~w_in_empty & cmp_ready;
  assign w_out_push = dec_valid & ~w_out_full;
  assign w_out_pop  = w_out_rd & ~w_out_empty;
  assign w_flush    = w_ctrl_wr & {NUM_CH{wb.wb_wdata[1]}};

  assign cmp_valid = ~w_in_empty;
  assign dec_ready = ~w_out_full;
  assign irq       = r_irq;

  always_comb begin
    cmp_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cmp_data[8*c +: 8] = r_in_mem[c][r_in_rp[c]];
    end
  end

`ifdef BRIDGE_STICKY_ERR_EN
  logic [NUM_CH-1:0] r_ovf, r_udf, w_clr_err;

  assign w_clr_err = w_ctrl_wr & {NUM_CH{wb.wb_wdata[2]}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= '0;
      r_udf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~w_clr_err) | (w_in_wr & w_in_full);
      r_udf <= (r_udf & ~w_clr_err) | (w_out_rd & w_out_empty);
    end
  end

  assign w_ovf = r_ovf;
  assign w_udf = r_udf;
`else
  assign w_ovf = '0;
  assign w_udf = '0;
`endif

  always_comb begin
    w_rdata_nxt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_hit[c] && !wb.wb_we) begin
        case (w_reg)
          2'd1: begin
            if (!w_out_empty[c]) begin
              w_rdata_nxt = {24'h0, r_out_mem[c][r_out_rp[c]]};
            end
          end
          2'd2: begin
            w_rdata_nxt = {8'h0, 8'(r_in_cnt[c]), 8'(r_out_cnt[c]), 2'b00,
                           w_udf[c], w_ovf[c], w_out_empty[c], w_out_full[c],
                           w_in_empty[c], w_in_full[c]};
          end
          2'd3:    w_rdata_nxt = {31'h0, r_irq_en[c]};
          default: w_rdata_nxt = '0;
        endcase
      end
    end
  end

  // Pointer/count state; flush overrides any same-cycle stream or bus traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_en <= '0;
      r_irq    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_in_wp[c]   <= '0;
        r_in_rp[c]   <= '0;
        r_out_wp[c]  <= '0;
        r_out_rp[c]  <= '0;
        r_in_cnt[c]  <= '0;
        r_out_cnt[c] <= '0;
      end
    end else begin
      r_irq <= r_irq_en & (~w_out_empty | w_ovf | w_udf);
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ctrl_wr[c]) begin
          r_irq_en[c] <= wb.wb_wdata[0];
        end
        if (w_flush[c]) begin
          r_in_wp[c]   <= '0;
          r_in_rp[c]   <= '0;
          r_out_wp[c]  <= '0;
          r_out_rp[c]  <= '0;
          r_in_cnt[c]  <= '0;
          r_out_cnt[c] <= '0;
        end else begin
          if (w_in_push[c])  r_in_wp[c]  <= r_in_wp[c] + 1'b1;
          if (w_in_pop[c])   r_in_rp[c]  <= r_in_rp[c] + 1'b1;
          if (w_out_push[c]) r_out_wp[c] <= r_out_wp[c] + 1'b1;
          if (w_out_pop[c])  r_out_rp[c] <= r_out_rp[c] + 1'b1;
          r_in_cnt[c]  <= r_in_cnt[c] + CW'(w_in_push[c]) - CW'(w_in_pop[c]);
          r_out_cnt[c] <= r_out_cnt[c] + CW'(w_out_push[c]) - CW'(w_out_pop[c]);
        end
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters alone.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_in_push[c]) begin
        r_in_mem[c][r_in_wp[c]] <= wb.wb_wdata[7:0];
      end
      if (w_out_push[c]) begin
        r_out_mem[c][r_out_wp[c]] <= dec_data[8*c +: 8];
      end
    end
  end

endmodule
